// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: memory-mapped machine timer (mtime/mtimecmp) and software
// interrupt (msip) source with a prioritized cause code for the CSR block.
module timer_irq_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        wr_en,
   input  logic        rd_en,
   output logic [31:0] rdata,
   output logic        timer_irq,
   output logic        soft_irq,
   output logic        irq_pending,
   output logic [31:0] irq_cause
);

   // Word offsets (byte offset >> 2) of the mapped registers
   localparam logic [13:0] W_MSIP    = 14'h0000;  // 0x0000
   localparam logic [13:0] W_CMP_LO  = 14'h1000;  // 0x4000
   localparam logic [13:0] W_CMP_HI  = 14'h1001;  // 0x4004
   localparam logic [13:0] W_TIME_LO = 14'h2FFE;  // 0xBFF8
   localparam logic [13:0] W_TIME_HI = 14'h2FFF;  // 0xBFFC

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   logic [15:0] presc_q, presc_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d;
   logic        timer_irq_q, timer_irq_d;
   logic        soft_irq_q, soft_irq_d;

   logic [31:0] offset;
   logic        in_win;
   logic [13:0] word;
   logic        wr, rd, tick;
   logic [63:0] mtime_inc;

   // Accesses are word-only; the byte-lane bits are deliberately ignored.
   logic unused_byte_lane;
   assign unused_byte_lane = ^addr[1:0];

   assign offset = addr - BASE_ADDR;
   assign in_win = (offset[31:16] == 16'h0000);
   assign word   = offset[15:2];
   assign wr     = sel & wr_en & in_win;
   assign rd     = sel & rd_en & in_win;

   // Prescaler: wraps at PRESCALE-1 and emits a one-cycle tick on the wrap
   always_comb begin
      tick    = (presc_q == PRESC_MAX);
      presc_d = tick ? 16'h0000 : presc_q + 16'h0001;
   end

   // mtime next state: full 64-bit increment, a written half overrides, and a
   // low-half write also drops the carry into the high half
   always_comb begin
      mtime_inc = mtime_q + {63'b0, tick};
      mtime_d   = mtime_inc;
      if (wr && word == W_TIME_LO) begin
         mtime_d = {mtime_q[63:32], wdata};
      end else if (wr && word == W_TIME_HI) begin
         mtime_d = {wdata, mtime_inc[31:0]};
      end
   end

   // mtimecmp / msip next state and interrupt sampling of pre-edge values
   always_comb begin
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      if (wr && word == W_CMP_LO) mtimecmp_d[31:0]  = wdata;
      if (wr && word == W_CMP_HI) mtimecmp_d[63:32] = wdata;
      if (wr && word == W_MSIP)   msip_d            = wdata[0];
      timer_irq_d = (mtime_q >= mtimecmp_q);
      soft_irq_d  = msip_q;
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q     <= 16'h0000;
         mtime_q     <= 64'h0;
         mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
         msip_q      <= 1'b0;
         timer_irq_q <= 1'b0;
         soft_irq_q  <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         msip_q      <= msip_d;
         timer_irq_q <= timer_irq_d;
         soft_irq_q  <= soft_irq_d;
      end
   end

   // Combinational read mux; returns pre-write values on a simultaneous store
   always_comb begin
      rdata = 32'h0;
      if (rd) begin
         case (word)
            W_MSIP:    rdata = {31'b0, msip_q};
            W_CMP_LO:  rdata = mtimecmp_q[31:0];
            W_CMP_HI:  rdata = mtimecmp_q[63:32];
            W_TIME_LO: rdata = mtime_q[31:0];
            W_TIME_HI: rdata = mtime_q[63:32];
            default:   rdata = 32'h0;
         endcase
      end
   end

   // Interrupt outputs and prioritized cause (software above timer)
   always_comb begin
      timer_irq   = timer_irq_q;
      soft_irq    = soft_irq_q;
      irq_pending = timer_irq_q | soft_irq_q;
      if (soft_irq_q)       irq_cause = 32'h8000_0003;
      else if (timer_irq_q) irq_cause = 32'h8000_0007;
      else                  irq_cause = 32'h0000_0000;
   end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: two instances (PRESCALE 1 and 4) share one bus and
// are checked against a register-level behavioural model of the timer.
module tb_timer_irq_ctrl;

   localparam logic [31:0] BASE = 32'h0200_0000;

   logic        clk, rst_n, sel, wr_en, rd_en;
   logic [31:0] addr, wdata;
   logic [31:0] rdata_a, rdata_b, cause_a, cause_b;
   logic        tirq_a, tirq_b, sirq_a, sirq_b, pend_a, pend_b;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4
   int unsigned PR[2] = '{1, 4};
   int unsigned k;                 // edges since reset release
   logic [63:0] m_time[2];
   logic [63:0] m_cmp[2];
   logic        m_msip[2], m_tirq[2], m_sirq[2];

   timer_irq_ctrl #(.BASE_ADDR(BASE), .PRESCALE(1)) u_p1 (
      .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata),
      .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata_a), .timer_irq(tirq_a),
      .soft_irq(sirq_a), .irq_pending(pend_a), .irq_cause(cause_a));

   timer_irq_ctrl #(.BASE_ADDR(BASE), .PRESCALE(4)) u_p4 (
      .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata),
      .wr_en(wr_en), .rd_en(rd_en), .rdata(rdata_b), .timer_irq(tirq_b),
      .soft_irq(sirq_b), .irq_pending(pend_b), .irq_cause(cause_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Register index of an address: 0 msip, 1 cmp lo, 2 cmp hi, 3 time lo, 4 time hi, -1 none
   function automatic int region(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      if (off >= 32'h0001_0000) return -1;
      case ({off[15:2], 2'b00})
         16'h0000: return 0;
         16'h4000: return 1;
         16'h4004: return 2;
         16'hBFF8: return 3;
         16'hBFFC: return 4;
         default:  return -1;
      endcase
   endfunction

   function automatic logic [31:0] mread(input int i, input logic [31:0] a);
      case (region(a))
         0:       return {31'b0, m_msip[i]};
         1:       return m_cmp[i][31:0];
         2:       return m_cmp[i][63:32];
         3:       return m_time[i][31:0];
         4:       return m_time[i][63:32];
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] mcause(input int i);
      if (m_sirq[i]) return 32'h8000_0003;
      if (m_tirq[i]) return 32'h8000_0007;
      return 32'h0;
   endfunction

   task automatic model_reset();
      k = 0;
      for (int i = 0; i < 2; i++) begin
         m_time[i] = 64'h0;
         m_cmp[i]  = 64'hFFFF_FFFF_FFFF_FFFF;
         m_msip[i] = 1'b0;
         m_tirq[i] = 1'b0;
         m_sirq[i] = 1'b0;
      end
   endtask

   task automatic check_outs(input string when);
      chk($sformatf("%s tirq p1", when), 64'(tirq_a), 64'(m_tirq[0]));
      chk($sformatf("%s tirq p4", when), 64'(tirq_b), 64'(m_tirq[1]));
      chk($sformatf("%s sirq p1", when), 64'(sirq_a), 64'(m_sirq[0]));
      chk($sformatf("%s sirq p4", when), 64'(sirq_b), 64'(m_sirq[1]));
      chk($sformatf("%s pend p1", when), 64'(pend_a), 64'(m_tirq[0] | m_sirq[0]));
      chk($sformatf("%s pend p4", when), 64'(pend_b), 64'(m_tirq[1] | m_sirq[1]));
      chk($sformatf("%s cause p1", when), 64'(cause_a), 64'(mcause(0)));
      chk($sformatf("%s cause p4", when), 64'(cause_b), 64'(mcause(1)));
   endtask

   // One bus cycle: drive, check the combinational read, clock, update model, check irqs
   task automatic do_cycle(input logic s, input logic w, input logic r,
                           input logic [31:0] a, input logic [31:0] d, input string tag);
      logic        tk;
      logic [63:0] inc;
      logic        nt;
      sel = s; wr_en = w; rd_en = r; addr = a; wdata = d;
      #1;
      chk($sformatf("%s rdata p1 @%h", tag, a), 64'(rdata_a), 64'((s && r) ? mread(0, a) : 32'h0));
      chk($sformatf("%s rdata p4 @%h", tag, a), 64'(rdata_b), 64'((s && r) ? mread(1, a) : 32'h0));
      @(posedge clk);
      k++;
      for (int i = 0; i < 2; i++) begin
         tk  = ((k % PR[i]) == 0);
         inc = m_time[i] + 64'(tk);
         nt  = (m_time[i] >= m_cmp[i]);
         m_sirq[i] = m_msip[i];
         m_tirq[i] = nt;
         if (s && w) begin
            case (region(a))
               0: m_msip[i] = d[0];
               1: m_cmp[i][31:0]  = d;
               2: m_cmp[i][63:32] = d;
               3: inc = {m_time[i][63:32], d};
               4: inc = {d, inc[31:0]};
               default: ;
            endcase
         end
         m_time[i] = inc;
      end
      #1;
      check_outs(tag);
   endtask

   task automatic wr32(input logic [31:0] off, input logic [31:0] d, input string tag);
      do_cycle(1'b1, 1'b1, 1'b0, BASE + off, d, tag);
   endtask

   task automatic rd32(input logic [31:0] off, input string tag);
      do_cycle(1'b1, 1'b0, 1'b1, BASE + off, 32'h0, tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int j = 0; j < n; j++) do_cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, tag);
   endtask

   initial begin
      logic [31:0] ra, rdv;
      int          pick;
      sel = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 32'h0; wdata = 32'h0;
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outs("reset");
      rst_n = 1'b1;

      // Reset values visible on the bus, quiet interrupts
      rd32(32'hBFF8, "rst_mtime_lo");
      rd32(32'h4004, "rst_cmp_hi");
      rd32(32'h4000, "rst_cmp_lo");
      rd32(32'h0000, "rst_msip");
      idle(20, "rst_idle");

      // Prescale and carry across the word boundary
      wr32(32'hBFF8, 32'hFFFF_FFFE, "carry_wlo");
      wr32(32'hBFFC, 32'h0000_0000, "carry_whi");
      idle(8, "carry_wait");
      rd32(32'hBFF8, "carry_rlo");
      rd32(32'hBFFC, "carry_rhi");

      // All-ones wraps to zero
      wr32(32'hBFFC, 32'hFFFF_FFFF, "wrap_whi");
      wr32(32'hBFF8, 32'hFFFF_FFFF, "wrap_wlo");
      idle(4, "wrap_wait");
      rd32(32'hBFF8, "wrap_rlo");
      rd32(32'hBFFC, "wrap_rhi");

      // Compare fire and clear
      wr32(32'hBFFC, 32'h0, "cmp_time_hi");
      wr32(32'hBFF8, 32'h10, "cmp_time_lo");
      wr32(32'h4004, 32'hFFFF_FFFF, "cmp_hi_ones");
      wr32(32'h4000, 32'h20, "cmp_lo");
      wr32(32'h4004, 32'h0, "cmp_hi");
      idle(40, "cmp_fire");
      wr32(32'h4000, 32'hFFFF_FFFF, "cmp_clear");
      idle(4, "cmp_drop");

      // Priority of the software interrupt over the timer
      wr32(32'h4000, 32'h0, "prio_cmp0");
      idle(3, "prio_tim");
      wr32(32'h0000, 32'h1, "prio_msip1");
      idle(3, "prio_sw");
      rd32(32'h0000, "prio_rd_msip");
      wr32(32'h0000, 32'h0, "prio_msip0");
      idle(3, "prio_back");

      // Low-word write colliding with a carry-producing tick
      wr32(32'hBFFC, 32'h7, "coll_whi");
      wr32(32'hBFF8, 32'hFFFF_FFFF, "coll_wlo1");
      wr32(32'hBFF8, 32'h5, "coll_wlo2");
      rd32(32'hBFF8, "coll_rlo");
      rd32(32'hBFFC, "coll_rhi");
      // Simultaneous read and write returns the old value
      do_cycle(1'b1, 1'b1, 1'b1, BASE + 32'h4000, 32'h1234_5678, "rw_same");
      rd32(32'h4000, "rw_after");
      // Out-of-window and unmapped accesses read zero and do not write
      do_cycle(1'b1, 1'b1, 1'b1, BASE + 32'h0001_0000, 32'hDEAD_BEEF, "oow");
      do_cycle(1'b1, 1'b1, 1'b1, BASE - 32'h4, 32'hDEAD_BEEF, "below");
      do_cycle(1'b1, 1'b1, 1'b1, BASE + 32'h0000_0100, 32'hDEAD_BEEF, "unmapped");
      rd32(32'h4000, "unmapped_after");

      // Asynchronous reset between edges while the timer interrupt is active
      wr32(32'h4000, 32'h0, "mrst_cmp_lo");
      wr32(32'h4004, 32'h0, "mrst_cmp_hi");
      idle(3, "mrst_arm");
      chk("mrst armed p1", 64'(tirq_a), 64'h1);
      #2;
      rst_n = 1'b0;
      sel = 1'b1; rd_en = 1'b1; wr_en = 1'b0; addr = BASE + 32'hBFF8;
      #1;
      model_reset();
      check_outs("mrst");
      chk("mrst mtime p1", 64'(rdata_a), 64'h0);
      chk("mrst mtime p4", 64'(rdata_b), 64'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd32(32'hBFF8, "post_mrst");
      idle(5, "post_mrst_idle");

      // Randomized traffic against the model
      for (int n = 0; n < 500; n++) begin
         pick = int'($urandom_range(0, 9));
         case (pick)
            0:       ra = BASE + 32'h0000;
            1:       ra = BASE + 32'h4000;
            2:       ra = BASE + 32'h4004;
            3:       ra = BASE + 32'hBFF8;
            4:       ra = BASE + 32'hBFFC;
            5:       ra = BASE + ($urandom & 32'h0000_FFFF);
            6:       ra = BASE + 32'h0001_0000 + ($urandom & 32'h00FF_FFFF);
            default: ra = BASE + 32'h4000;
         endcase
         ra[1:0] = 2'($urandom);
         if ($urandom_range(0, 1) == 1) rdv = $urandom;
         else rdv = m_time[0][31:0] + $urandom_range(0, 60);
         if (pick == 2 || pick == 4) rdv = $urandom_range(0, 1) == 1 ? 32'h0 : rdv;
         do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, ra, rdv, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
